// File: rtl/row_crop_if.sv
// AXI4-Stream video bus used on both sides of row_crop.
// Master drives payload and valid; slave drives ready.
interface row_crop_if #(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8,
  parameter int PPC         = 2
);
  logic [TUSER_WIDTH-1:0]     tuser;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  logic [PPC*TDATA_WIDTH-1:0] tdata;

  modport master (
    output tuser, tdest, tvalid, tlast, tdata,
    input  tready
  );

  modport slave (
    input  tuser, tdest, tvalid, tlast, tdata,
    output tready
  );
endinterface

// File: rtl/row_crop.sv
// Strips PAD border pixels from both ends of each row of a video stream.
// Optional rows_done statistics counter: define ROW_CROP_STATS_EN.
module row_crop #(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8,
  parameter int PPC         = 2,
  parameter int PAD         = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  row_crop_if.slave   s_axis,
  row_crop_if.master  m_axis,
  output logic        row_err,
  output logic [15:0] rows_done
);

  localparam int BW = PPC * TDATA_WIDTH;
  localparam int D  = PAD / PPC;
  localparam int CW = $clog2(D + 1);
  localparam int UW = TUSER_WIDTH - 1;
  // entry = {tdata, tuser[top:1], tdest}; SOF lives in sof_q
  localparam int EW = BW + UW + TDEST_WIDTH;

  typedef enum logic [1:0] {
    S_HEAD,
    S_FILL,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [D-1:0][EW-1:0]  buf_q, buf_d;
  logic                  sof_q, sof_d;
  logic                  mv_q, mv_d;
  logic [BW-1:0]         md_q, md_d;
  logic [TUSER_WIDTH-1:0] mu_q, mu_d;
  logic [TDEST_WIDTH-1:0] mt_q, mt_d;
  logic                  ml_q, ml_d;
  logic                  err_q, err_d;

  logic                  s_rdy;
  logic                  acc;
  logic                  emit;
  logic [EW-1:0]         in_e;
  logic [EW-1:0]         pop;

  assign s_rdy = rst_n & (~mv_q | m_axis.tready);
  assign acc   = s_axis.tvalid & s_rdy;
  assign in_e  = {s_axis.tdata,
                  s_axis.tuser[TUSER_WIDTH-1:1],
                  s_axis.tdest};
  assign pop   = buf_q[D-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    mv_d    = mv_q;
    md_d    = md_q;
    mu_d    = mu_q;
    mt_d    = mt_q;
    ml_d    = ml_q;
    err_d   = 1'b0;
    emit    = 1'b0;
    if (m_axis.tready) mv_d = 1'b0;
    if (acc) begin
      unique case (state_q)
        S_HEAD: begin
          if (s_axis.tlast) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == CW'(D - 1)) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FILL: begin
          if (s_axis.tlast) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            buf_d   = '0;
            state_d = S_HEAD;
          end else begin
            buf_d[0] = in_e;
            for (int i = 1; i < D; i++) buf_d[i] = buf_q[i-1];
            if (cnt_q == CW'(D - 1)) begin
              cnt_d   = '0;
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_RUN: begin
          emit = 1'b1;
          mv_d = 1'b1;
          md_d = pop[EW-1 -: BW];
          mu_d = {pop[TDEST_WIDTH +: UW], sof_q};
          mt_d = pop[TDEST_WIDTH-1:0];
          ml_d = s_axis.tlast;
          if (s_axis.tlast) begin
            // trailing pad still in the buffer is thrown away
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_HEAD;
          end else begin
            buf_d[0] = in_e;
            for (int i = 1; i < D; i++) buf_d[i] = buf_q[i-1];
          end
        end
        default: begin
          state_d = S_HEAD;
          cnt_d   = '0;
          buf_d   = '0;
        end
      endcase
    end
    sof_d = (sof_q & ~emit) | (acc & s_axis.tuser[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HEAD;
      cnt_q   <= '0;
      buf_q   <= '0;
      sof_q   <= 1'b0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      mu_q    <= '0;
      mt_q    <= '0;
      ml_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      sof_q   <= sof_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      mu_q    <= mu_d;
      mt_q    <= mt_d;
      ml_q    <= ml_d;
      err_q   <= err_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = mv_q;
  assign m_axis.tdata  = md_q;
  assign m_axis.tuser  = mu_q;
  assign m_axis.tdest  = mt_q;
  assign m_axis.tlast  = ml_q;
  assign row_err       = err_q;

`ifdef ROW_CROP_STATS_EN
  logic [15:0] rd_q;

  // a frame start restarts the count at this row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (mv_q & m_axis.tready) begin
      if (mu_q[0])   rd_q <= {15'd0, ml_q};
      else if (ml_q) rd_q <= rd_q + 16'd1;
    end
  end

  assign rows_done = rd_q;
`else
  assign rows_done = '0;
`endif

endmodule

// File: tb/tb_row_crop.sv
// Randomized self-checking bench for row_crop.
// Reference model crops each row as a whole list of beats.
module tb_row_crop;

  localparam int D = 1;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  u;
    logic [1:0]  t;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        row_err;
  logic [15:0] rows_done;

  row_crop_if s_if ();
  row_crop_if m_if ();

  row_crop dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .row_err   (row_err),
    .rows_done (rows_done)
  );

  int    n_tests;
  int    n_fail;
  int    rmode;
  int    pc;
  int    err_seen;
  int    err_m;
  int    rows_m;
  bit    pend_m;
  bit    gaps;
  beat_t exp_q[$];
  beat_t row_q[$];
  beat_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cropped row = beats D..n-D-1; SOF goes to the next emitted beat.
  task automatic model_row();
    int n;
    n = row_q.size();
    for (int j = 0; j < n; j++) begin
      if (n >= 2*D+1 && j >= 2*D) begin
        beat_t e;
        e   = row_q[j-D];
        e.u = {row_q[j-D].u[4:1], pend_m};
        e.l = (j == n-1);
        pend_m = 1'b0;
        exp_q.push_back(e);
      end
      if (row_q[j].u[0]) pend_m = 1'b1;
    end
    if (n < 2*D+1) err_m++;
  endtask

  initial begin
    m_if.tready = 1'b0;
    pc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_if.tready = 1'b1;
        1: m_if.tready = 1'($urandom_range(0, 1));
        2: begin
          m_if.tready = (pc % 3 == 0);
          pc++;
        end
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_tready", s_if.tready, !m_if.tvalid || m_if.tready);
      if (row_err) err_seen++;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", m_if.tdata, mon_e.d);
          chk("tlast", m_if.tlast, mon_e.l);
          chk("tuser", m_if.tuser, mon_e.u);
          chk("tdest", m_if.tdest, mon_e.t);
          if (mon_e.u[0])  rows_m = mon_e.l ? 1 : 0;
          else if (mon_e.l) rows_m++;
        end
      end
    end
  end

  task automatic put_beat(beat_t b);
    int k;
    k = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.d;
    s_if.tuser  = b.u;
    s_if.tdest  = b.t;
    s_if.tlast  = b.l;
    do begin
      @(negedge clk);
      k++;
    end while (!s_if.tready && k < 2000);
    if (!s_if.tready) chk("in_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_row();
    model_row();
    for (int j = 0; j < row_q.size(); j++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      put_beat(row_q[j]);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic mk_row(int n, bit sof, logic [1:0] td, logic [15:0] base);
    beat_t b;
    row_q.delete();
    for (int j = 0; j < n; j++) begin
      b.d = base + 16'(j * 16'h0202);
      b.u = (j == 0 && sof) ? 5'b00001 : 5'b00000;
      b.t = td;
      b.l = (j == n-1);
      row_q.push_back(b);
    end
  endtask

  task automatic add(logic [15:0] d, logic [4:0] u, logic [1:0] t, logic l);
    beat_t b;
    b.d = d;
    b.u = u;
    b.t = t;
    b.l = l;
    row_q.push_back(b);
  endtask

  task automatic basic_row();
    row_q.delete();
    add(16'h0A0B, 5'b00001, 2'd2, 1'b0);
    add(16'h0102, 5'b00000, 2'd2, 1'b0);
    add(16'h0304, 5'b00000, 2'd2, 1'b0);
    add(16'h0506, 5'b00000, 2'd2, 1'b0);
    add(16'h0708, 5'b00000, 2'd2, 1'b0);
    add(16'h0C0D, 5'b00000, 2'd2, 1'b1);
  endtask

  task automatic chk_rows(string tag);
`ifdef ROW_CROP_STATS_EN
    chk(tag, rows_done, 32'(rows_m));
`else
    chk(tag, rows_done, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ur;
    n_tests = 0;
    n_fail = 0;
    rmode = 0;
    err_seen = 0;
    err_m = 0;
    rows_m = 0;
    pend_m = 1'b0;
    gaps = 1'b0;
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tuser = '0;
    s_if.tdest = '0;
    s_if.tlast = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_row_err", row_err, 0);
    chk("rst_rows_done", rows_done, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_tready", s_if.tready, 1);

    rmode = 0;
    basic_row();
    send_row();
    drain();

    rmode = 2;
    basic_row();
    send_row();
    drain();

    rmode = 1;
    row_q.delete();
    add(16'hAAAA, 5'b00001, 2'd1, 1'b0);
    add(16'hBBBB, 5'b00000, 2'd1, 1'b1);
    send_row();
    row_q.delete();
    add(16'h1111, 5'b10000, 2'd3, 1'b0);
    add(16'h2222, 5'b01010, 2'd3, 1'b0);
    add(16'h3333, 5'b00000, 2'd3, 1'b1);
    send_row();
    drain();
    chk("short_row_err", err_seen, err_m);

    gaps = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int n;
      beat_t b;
      n = $urandom_range(1, 10);
      row_q.delete();
      for (int j = 0; j < n; j++) begin
        ur = 4'($urandom);
        b.d = 16'($urandom);
        b.u = {ur, (j == 0) && ($urandom_range(0, 3) == 0)};
        b.t = 2'($urandom_range(0, 3));
        b.l = (j == n-1);
        row_q.push_back(b);
      end
      send_row();
    end
    drain();
    gaps = 1'b0;
    chk("rand_row_err", err_seen, err_m);
    chk_rows("rand_rows_done");

    rmode = 3;
    repeat (2) @(posedge clk);
    #1;
    mk_row(6, 1'b0, 2'd0, 16'h4000);
    for (int j = 0; j < 3; j++) put_beat(row_q[j]);
    chk("pre_rst_valid", m_if.tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_if.tvalid, 0);
    chk("async_rst_tready", s_if.tready, 0);
    pend_m = 1'b0;
    rows_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rmode = 1;
    mk_row(6, 1'b0, 2'd1, 16'h5100);
    send_row();
    drain();
    chk_rows("rst_rows_done");

    for (int r = 0; r < 3; r++) begin
      mk_row(6, 1'b0, 2'd2, 16'(16'h6000 + r * 16'h0100));
      send_row();
    end
    drain();
    chk_rows("stats_3rows");
    mk_row(6, 1'b1, 2'd3, 16'h7000);
    send_row();
    drain();
    chk_rows("stats_sof");

    chk("err_total", err_seen, err_m);
    chk("exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
